fsm_seq_ctrl: RTL and testbench

FSM_SEQ_CTRL -- requirements
Module: fsm_seq_ctrl

---
 rtl/fsm_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fsm_seq_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl
// Drives a bit pattern, one bit per cycle, into an external 8-state x/y FSM.
// The FSM is reset and its state is checked before the pattern starts.
// For each bit sent, the FSM's Mealy y response is recorded. The FSM state
// after the last bit is also captured.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   start        one-cycle request to run a sequence (honoured only in IDLE)
//   abort        cancels a run in INIT, CHECK or RUN
//   pattern      x bits to drive, bit 0 first (latched on accepted start)
//   len          number of bits to drive, 1..MAXLEN (latched on accepted start)
//   fsm_rst      reset to the controlled FSM
//   x_out        x input driven to the controlled FSM
//   y_in         y output of the controlled FSM, valid in the same cycle as x_out
//   state_in     current-state tap of the controlled FSM
//   busy         high whenever the controller is not IDLE
//   done         one-cycle completion pulse (also pulses on a rejected start)
//   err          sticky error flag, cleared by the next accepted start
//   y_capture    bit k holds the y observed while x bit k was driven
//   ones_count   number of y==1 samples in the last run
//   final_state  state_in sampled in the cycle after the last x bit
module fsm_seq_ctrl #(
  parameter int MAXLEN = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [MAXLEN-1:0]       pattern,
  input  logic [$clog2(MAXLEN):0] len,
  output logic                    fsm_rst,
  output logic                    x_out,
  input  logic                    y_in,
  input  logic [2:0]              state_in,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [MAXLEN-1:0]       y_capture,
  output logic [$clog2(MAXLEN):0] ones_count,
  output logic [2:0]              final_state
);

  localparam int LW = $clog2(MAXLEN) + 1;
  localparam int KW = $clog2(MAXLEN);

  typedef enum logic [2:0] {IDLE, INIT, CHECK, RUN, FINISH} state_t;

  state_t            state, state_next;
  logic [MAXLEN-1:0] pat_q;
  logic [LW-1:0]     len_q;
  logic [KW-1:0]     k_q;
  logic              abort_rst;

  logic len_ok, last_bit;
  logic accept, reject, capture, aborting, check_fail;

  assign len_ok   = (len != '0) && (len <= LW'(MAXLEN));
  assign last_bit = ({1'b0, k_q} == (len_q - LW'(1)));

  // Next-state and output decode. The strobes computed here tell the register
  // process which bookkeeping to do at the closing edge of this cycle.
  // The x/y FSM is reset in INIT, in the IDLE cycle that follows an abort,
  // and throughout the controller's own reset.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    capture    = 1'b0;
    aborting   = 1'b0;
    check_fail = 1'b0;
    x_out      = 1'b0;
    busy       = (state != IDLE);
    fsm_rst    = abort_rst;

    case (state)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            accept     = 1'b1;
            state_next = INIT;
          end else begin
            reject = 1'b1;
          end
        end
      end
      INIT: begin
        fsm_rst = 1'b1;
        if (abort) begin
          aborting   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          aborting   = 1'b1;
          state_next = IDLE;
        end else if (state_in != 3'b000) begin
          check_fail = 1'b1;
          state_next = FINISH;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        x_out = pat_q[k_q];
        // An aborted RUN cycle does not record its y sample.
        if (abort) begin
          aborting   = 1'b1;
          state_next = IDLE;
        end else begin
          capture = 1'b1;
          if (last_bit) state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (reset) fsm_rst = 1'b1;
  end

  // State and datapath registers. done is registered, so it is high during
  // FINISH. After a rejected start, done is high in the following IDLE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      k_q         <= '0;
      abort_rst   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      y_capture   <= '0;
      ones_count  <= '0;
      final_state <= '0;
    end else begin
      state     <= state_next;
      abort_rst <= aborting;
      done      <= reject || (state_next == FINISH);

      if (accept) begin
        pat_q      <= pattern;
        len_q      <= len;
        y_capture  <= '0;
        ones_count <= '0;
        err        <= 1'b0;
      end

      if (reject || aborting || check_fail) err <= 1'b1;

      if (state == CHECK) k_q <= '0;

      if (capture) begin
        y_capture[k_q] <= y_in;
        ones_count     <= ones_count + LW'(y_in);
        if (!last_bit) k_q <= k_q + KW'(1);
      end

      if (state == FINISH) final_state <= state_in;
    end
  end

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// tb_fsm_seq_ctrl
// Testbench for fsm_seq_ctrl. The DUT is paired with a behavioural 8-state x/y
// FSM that stands in for the team's FSM. That FSM holds its reset for one extra
// cycle, so it is still in S0 when the first x bit is presented.
// The stimulus process queues expected results. The monitor process pops an
// entry whenever a run ends (busy falls) or a rejected start pulses done.
//
// Ports: none (top-level bench).
module tb_fsm_seq_ctrl;

  localparam int MAXLEN = 16;

  localparam int K_NORMAL     = 0;
  localparam int K_INVALID    = 1;
  localparam int K_ABORT      = 2;
  localparam int K_FINABORT   = 3;
  localparam int K_BUSYSTART  = 4;
  localparam int K_CHECKFAIL  = 5;
  localparam int K_RESET      = 6;
  localparam int K_STARTABORT = 7;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic        fsm_rst;
  logic        x_out;
  logic        y_in;
  logic [2:0]  state_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] y_capture;
  logic [4:0]  ones_count;
  logic [2:0]  final_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] xs;
    int          xn;
    logic        check_x;
    int          done_cnt;
    logic        last_done;
    logic        err;
    logic [15:0] ycap;
    logic [4:0]  ones;
    logic [2:0]  fin;
    logic        fsm_rst;
    logic        invalid;
  } exp_t;

  exp_t sb_q[$];

  // Reference view of the DUT's result registers between runs.
  logic [15:0] m_ycap;
  logic [4:0]  m_ones;
  logic [2:0]  m_fin;

  fsm_seq_ctrl #(.MAXLEN(MAXLEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .pattern     (pattern),
    .len         (len),
    .fsm_rst     (fsm_rst),
    .x_out       (x_out),
    .y_in        (y_in),
    .state_in    (state_in),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .y_capture   (y_capture),
    .ones_count  (ones_count),
    .final_state (final_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Transition table of the controlled FSM.
  function automatic logic [2:0] fsm_next(input logic [2:0] s, input logic x);
    case (s)
      3'd0: return x ? 3'd1 : 3'd5;
      3'd1: return x ? 3'd2 : 3'd4;
      3'd2: return x ? 3'd3 : 3'd6;
      3'd3: return x ? 3'd2 : 3'd7;
      3'd4: return x ? 3'd3 : 3'd0;
      3'd5: return x ? 3'd6 : 3'd5;
      3'd6: return x ? 3'd7 : 3'd1;
      default: return x ? 3'd4 : 3'd0;
    endcase
  endfunction

  // Mealy output table of the controlled FSM.
  function automatic logic fsm_y(input logic [2:0] s, input logic x);
    case (s)
      3'd0: return 1'b0;
      3'd1: return !x;
      3'd2: return 1'b0;
      3'd3: return !x;
      3'd4: return 1'b1;
      3'd5: return !x;
      default: return x;
    endcase
  endfunction

  logic [2:0] fsm_state;
  logic       rst_stretch;
  logic       force_en;

  always_ff @(posedge clk) begin
    rst_stretch <= fsm_rst;
    if (fsm_rst || rst_stretch) fsm_state <= 3'd0;
    else                        fsm_state <= fsm_next(fsm_state, x_out);
  end

  assign y_in     = fsm_y(fsm_state, x_out);
  assign state_in = force_en ? 3'b011 : fsm_state;

  // Walk the FSM from S0 over the first n bits of pat.
  function automatic void model_run(input logic [15:0] pat, input int n,
                                    output logic [15:0] ycap, output int ones,
                                    output logic [2:0] fin);
    logic [2:0] s;
    logic       y;
    s    = 3'd0;
    ycap = '0;
    ones = 0;
    for (int k = 0; k < n; k++) begin
      y       = fsm_y(s, pat[k]);
      ycap[k] = y;
      if (y) ones++;
      s = fsm_next(s, pat[k]);
    end
    fin = s;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: records x_out and done while busy. It compares against the
  // oldest queued expectation when a run ends or a rejected start reports.
  logic        mon_en    = 1'b0;
  int          obs_n     = 0;
  logic [63:0] obs_xs    = '0;
  int          done_cnt  = 0;
  logic        prev_busy = 1'b0;
  logic        prev_done = 1'b0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) begin
        if (obs_n < 64) obs_xs[obs_n] = x_out;
        obs_n++;
        if (done) done_cnt++;
      end
      if ((prev_busy && !busy) || (!prev_busy && !busy && done)) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_end actual=busy%0b_done%0b expected=no_event", busy, done);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.check_x) begin
            checkOutput("busy_cycles", 64'(obs_n), 64'(mon_e.xn));
            checkOutput("x_seq", obs_xs, mon_e.xs);
          end
          if (!mon_e.invalid)
            checkOutput("done_pulse", 64'(done_cnt * 2 + int'(prev_done)),
                        64'(mon_e.done_cnt * 2 + int'(mon_e.last_done)));
          checkOutput("err", 64'(err), 64'(mon_e.err));
          checkOutput("y_capture", 64'(y_capture), 64'(mon_e.ycap));
          checkOutput("ones_count", 64'(ones_count), 64'(mon_e.ones));
          checkOutput("final_state", 64'(final_state), 64'(mon_e.fin));
          checkOutput("fsm_rst", 64'(fsm_rst), 64'(mon_e.fsm_rst));
        end
        obs_n    = 0;
        obs_xs   = '0;
        done_cnt = 0;
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  // Issue one transaction, queue its expectation, and play the side events
  // (abort, stray start, forced state tap, reset) at cycle offset 'at' after
  // the start cycle. Inputs are scrambled while busy so the latching is tested.
  task automatic applyStimulus(input int kind, input logic [15:0] pat,
                               input logic [4:0] ln, input int at);
    exp_t        e;
    logic [15:0] yc;
    int          on;
    logic [2:0]  fn;
    int          total;
    int          nb;

    e.xs = '0;  e.xn = 0;  e.check_x = 1'b1;
    e.done_cnt = 0;  e.last_done = 1'b0;
    e.err = 1'b0;  e.ycap = '0;  e.ones = '0;  e.fin = '0;
    e.fsm_rst = 1'b0;  e.invalid = 1'b0;
    total = 0;

    case (kind)
      K_INVALID: begin
        e.invalid = 1'b1;
        e.err     = 1'b1;
        e.ycap    = m_ycap;
        e.ones    = m_ones;
        e.fin     = m_fin;
      end
      K_ABORT: begin
        nb = (at >= 3) ? at - 2 : 0;
        model_run(pat, (at >= 3) ? at - 3 : 0, yc, on, fn);
        e.xn      = at;
        e.xs      = (64'(pat) & ((64'd1 << nb) - 64'd1)) << 2;
        e.err     = 1'b1;
        e.ycap    = yc;
        e.ones    = 5'(on);
        e.fin     = m_fin;
        e.fsm_rst = 1'b1;
        m_ycap    = yc;
        m_ones    = 5'(on);
        total     = at;
      end
      K_CHECKFAIL: begin
        e.xn = 3;  e.done_cnt = 1;  e.last_done = 1'b1;  e.err = 1'b1;
        m_ycap = '0;  m_ones = '0;  m_fin = '0;
        total = 3;
      end
      K_RESET: begin
        e.check_x = 1'b0;
        e.fsm_rst = 1'b1;
        m_ycap = '0;  m_ones = '0;  m_fin = '0;
        total = at + 1;
      end
      default: begin
        model_run(pat, int'(ln), yc, on, fn);
        e.xn        = int'(ln) + 3;
        e.xs        = (64'(pat) & ((64'd1 << int'(ln)) - 64'd1)) << 2;
        e.done_cnt  = 1;
        e.last_done = 1'b1;
        e.ycap      = yc;
        e.ones      = 5'(on);
        e.fin       = fn;
        m_ycap = yc;  m_ones = 5'(on);  m_fin = fn;
        total = int'(ln) + 3;
      end
    endcase

    @(posedge clk); #1;
    start   = 1'b1;
    pattern = pat;
    len     = ln;
    abort   = (kind == K_STARTABORT);
    sb_q.push_back(e);

    for (int off = 1; off <= total; off++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      abort    = 1'b0;
      force_en = 1'b0;
      reset    = 1'b0;
      pattern  = 16'($urandom);
      len      = 5'($urandom);
      if ((kind == K_ABORT || kind == K_FINABORT) && off == at) abort = 1'b1;
      if (kind == K_BUSYSTART && off == at) start = 1'b1;
      if (kind == K_CHECKFAIL && off <= 2) force_en = 1'b1;
      if (kind == K_RESET && (off == at || off == at + 1)) reset = 1'b1;
    end

    @(posedge clk); #1;
    start    = 1'b0;
    abort    = 1'b0;
    force_en = 1'b0;
    reset    = 1'b0;

    if (kind == K_RESET) begin
      @(negedge clk);
      checkOutput("fsm_rst_release", 64'(fsm_rst), 64'd0);
    end

    for (int w = 0; w < 40 && sb_q.size() != 0; w++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL run_timeout actual=%0d_pending expected=0_pending kind=%0d", sb_q.size(), kind);
      sb_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int          kind;
    logic [4:0]  ln;
    int          at;

    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    pattern  = '0;
    len      = '0;
    force_en = 1'b0;
    m_ycap   = '0;
    m_ones   = '0;
    m_fin    = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_err", 64'(err), 64'd0);
    checkOutput("reset_x_out", 64'(x_out), 64'd0);
    checkOutput("reset_fsm_rst", 64'(fsm_rst), 64'd1);
    checkOutput("reset_y_capture", 64'(y_capture), 64'd0);
    checkOutput("reset_ones_count", 64'(ones_count), 64'd0);
    checkOutput("reset_final_state", 64'(final_state), 64'd0);

    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_release_fsm_rst", 64'(fsm_rst), 64'd0);
    mon_en = 1'b1;

    applyStimulus(K_NORMAL,     16'h000F, 5'd4,  0);
    applyStimulus(K_NORMAL,     16'h0000, 5'd3,  0);
    applyStimulus(K_INVALID,    16'h1234, 5'd0,  0);
    applyStimulus(K_INVALID,    16'h1234, 5'd17, 0);
    applyStimulus(K_ABORT,      16'hA5C3, 5'd8,  5);
    applyStimulus(K_ABORT,      16'h00FF, 5'd6,  1);
    applyStimulus(K_ABORT,      16'h00FF, 5'd6,  2);
    applyStimulus(K_RESET,      16'h5A5A, 5'd10, 6);
    applyStimulus(K_BUSYSTART,  16'h0F0F, 5'd10, 5);
    applyStimulus(K_CHECKFAIL,  16'hFFFF, 5'd5,  0);
    applyStimulus(K_NORMAL,     16'hFFFF, 5'd16, 0);
    applyStimulus(K_NORMAL,     16'h0001, 5'd1,  0);
    applyStimulus(K_FINABORT,   16'h3C3C, 5'd6,  9);
    applyStimulus(K_STARTABORT, 16'h9E37, 5'd5,  0);

    for (int i = 0; i < 120; i++) begin
      kind = int'($urandom_range(0, 7));
      ln   = 5'($urandom_range(1, 16));
      at   = 0;
      case (kind)
        K_INVALID:   ln = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
        K_ABORT:     at = int'($urandom_range(1, int'(ln) + 2));
        K_BUSYSTART: at = int'($urandom_range(1, int'(ln) + 2));
        K_RESET:     at = int'($urandom_range(3, int'(ln) + 2));
        K_FINABORT:  at = int'(ln) + 3;
        default:     at = 0;
      endcase
      applyStimulus(kind, 16'($urandom), ln, at);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
